// File: rtl/door_access_fsm.sv
// rtl/door_access_fsm.sv - door access controller: grants entry, counts failures, times lockout, latches alarm.
module door_access_fsm #(
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       submit,
    input  logic       equal,
    input  logic       alarm_clear,
    output logic       door_open,
    output logic       locked_out,
    output logic       alarm,
    output logic [3:0] fail_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_LOCK  = 2'd2,
        S_ALARM = 2'd3
    } state_e;

    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       MAX_CNT   = 4'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       fail_cnt_q, fail_cnt_d;
    logic             door_open_q, locked_out_q, alarm_q, busy_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (submit) begin
                    if (equal) begin
                        state_d    = S_OPEN;
                        timer_d    = OPEN_LOAD;
                        fail_cnt_d = '0;
                    end else if (fail_cnt_q + 4'd1 == MAX_CNT) begin
                        state_d    = S_LOCK;
                        timer_d    = LOCK_LOAD;
                        fail_cnt_d = MAX_CNT;
                    end else if (fail_cnt_q < MAX_CNT) begin
                        fail_cnt_d = fail_cnt_q + 4'd1;
                    end
                end
            end
            S_OPEN: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_LOCK: begin
                // Tampering outranks expiry on the same edge.
                if (submit) begin
                    state_d = S_ALARM;
                end else if (timer_q == '0) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_ALARM: begin
                if (alarm_clear) begin
                    state_d    = S_IDLE;
                    timer_d    = '0;
                    fail_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                timer_d    = '0;
                fail_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            fail_cnt_q   <= '0;
            door_open_q  <= 1'b0;
            locked_out_q <= 1'b0;
            alarm_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fail_cnt_q   <= fail_cnt_d;
            door_open_q  <= (state_d == S_OPEN);
            locked_out_q <= (state_d == S_LOCK);
            alarm_q      <= (state_d == S_ALARM);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign door_open  = door_open_q;
    assign locked_out = locked_out_q;
    assign alarm      = alarm_q;
    assign fail_cnt   = fail_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_door_access_fsm.sv
// tb/tb_door_access_fsm.sv - randomized and directed bench for door_access_fsm against a behavioural model.
module tb_door_access_fsm;

    localparam int MAX_TRIES   = 3;
    localparam int OPEN_CYCLES = 8;
    localparam int LOCK_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       submit = 1'b0;
    logic       equal = 1'b0;
    logic       alarm_clear = 1'b0;
    logic       door_open, locked_out, alarm, busy;
    logic [3:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    door_access_fsm #(
        .MAX_TRIES(MAX_TRIES), .OPEN_CYCLES(OPEN_CYCLES),
        .LOCK_CYCLES(LOCK_CYCLES), .TMR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .submit(submit), .equal(equal),
        .alarm_clear(alarm_clear), .door_open(door_open), .locked_out(locked_out),
        .alarm(alarm), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: remaining open/lock cycles, alarm latch, consecutive failures.
    int m_open = 0;
    int m_lock = 0;
    int m_fails = 0;
    bit m_alarm = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_open = 0; m_lock = 0; m_fails = 0; m_alarm = 0;
        end else if (m_alarm) begin
            if (alarm_clear) begin
                m_alarm = 0; m_fails = 0;
            end
        end else if (m_open > 0) begin
            m_open = m_open - 1;
        end else if (m_lock > 0) begin
            if (submit) begin
                m_alarm = 1; m_lock = 0;
            end else begin
                m_lock = m_lock - 1;
                if (m_lock == 0) m_fails = 0;
            end
        end else if (submit) begin
            if (equal) begin
                m_open = OPEN_CYCLES; m_fails = 0;
            end else begin
                m_fails = m_fails + 1;
                if (m_fails == MAX_TRIES) m_lock = LOCK_CYCLES;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] act, exp;
        act = {door_open, locked_out, alarm, busy, fail_cnt};
        exp = {m_open > 0, m_lock > 0, m_alarm, (m_open > 0) || (m_lock > 0) || m_alarm, 4'(m_fails)};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t actual open/lock/alarm/busy/cnt=%b required %b", $time, act, exp);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit e, input bit c);
        submit = s; equal = e; alarm_clear = c;
        @(posedge clk);
        #2;
        submit = 0; equal = 0; alarm_clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic async_reset_check(input string name);
        #1 reset = 1;
        #1;
        check(name, {door_open, locked_out, alarm, busy, fail_cnt}, 0);
        @(negedge clk);
        #1 reset = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_outputs", {door_open, locked_out, alarm, busy, fail_cnt}, 0);
        #1 reset = 0;
        @(posedge clk); #2;

        // Correct entry opens for exactly OPEN_CYCLES
        drive(1, 1, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (door_open) n++;
            check("busy_mirrors_open", busy, door_open);
            drive(0, 0, 0);
        end
        check("open_len", n, 8);

        // Two wrong then correct
        drive(1, 0, 0); check("fail_1", fail_cnt, 1);
        drive(1, 0, 0); check("fail_2", fail_cnt, 2);
        drive(1, 1, 0); check("fail_reset_on_ok", fail_cnt, 0);
        check("open_after_ok", door_open, 1);
        idle(10);

        // Lockout for exactly LOCK_CYCLES
        drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
        check("fail_3", fail_cnt, 3);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (locked_out) n++;
            drive(0, 0, 0);
        end
        check("lock_len", n, 16);
        check("fail_after_lock", fail_cnt, 0);
        drive(1, 1, 0); check("open_after_lock", door_open, 1);
        idle(10);

        // Tamper on lockout cycle 5, alarm latches until cleared
        drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
        idle(3);
        drive(1, 1, 0);
        check("alarm_on_tamper", {alarm, locked_out}, 2);
        idle(50);
        check("alarm_holds", alarm, 1);
        drive(1, 1, 1);
        check("alarm_cleared", {alarm, busy, fail_cnt}, 0);

        // Tamper on final lockout cycle
        drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
        idle(15);
        check("last_lock_cycle", locked_out, 1);
        drive(1, 0, 0);
        check("alarm_on_last", {alarm, locked_out}, 2);
        drive(0, 0, 1);

        // Submit during OPEN ignored; alarm_clear in IDLE ignored
        drive(1, 0, 0);
        drive(0, 0, 1);
        check("clear_in_idle", {busy, fail_cnt}, 1);
        drive(1, 1, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (door_open) n++;
            drive(i == 2, 0, 0);
        end
        check("open_len_submit", n, 8);
        check("fail_unchanged_open", fail_cnt, 0);

        // Async reset mid-OPEN and mid-ALARM
        drive(1, 1, 0); idle(2);
        async_reset_check("reset_mid_open");
        drive(1, 0, 0); check("fail_after_reset_open", fail_cnt, 1);
        drive(1, 0, 0); drive(1, 0, 0); idle(2); drive(1, 1, 0);
        check("in_alarm", alarm, 1);
        async_reset_check("reset_mid_alarm");
        drive(1, 0, 0); check("fail_after_reset_alarm", fail_cnt, 1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1;
                #3 reset = 0;
            end
            drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
